// File: rtl/regfile_pkg.sv
// regfile_pkg: default geometry and FSM state type shared by the register file blocks.
package regfile_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 8;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write bits with set-over-clear priority
// and two combinational lookup ports.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int  DEPTH  = DEFAULT_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_set_en,
    input  logic [ADDR_W-1:0] i_set_reg,
    input  logic              i_clr_en,
    input  logic [ADDR_W-1:0] i_clr_reg,
    input  logic [ADDR_W-1:0] i_rd_addr1,
    input  logic [ADDR_W-1:0] i_rd_addr2,
    output logic              o_busy1,
    output logic              o_busy2
);

    logic [DEPTH-1:0] r_busy;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy <= '0;
        end else begin
            if (i_clr_en) begin
                r_busy[i_clr_reg] <= 1'b0;
            end
            // A newly issued claim outranks a retiring write to the same register.
            if (i_set_en) begin
                r_busy[i_set_reg] <= 1'b1;
            end
        end
    end

    assign o_busy1 = r_busy[i_rd_addr1];
    assign o_busy2 = r_busy[i_rd_addr2];

endmodule

// File: rtl/regfile_param.sv
// regfile_param: parameterised 2R1W register file with init sequencer and scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
//
// state   | meaning
// ST_INIT | sequencer writes init value to one entry per cycle; outputs held at 0
// ST_RUN  | normal operation: writes, scoreboard updates, live read data
module regfile_param
    import regfile_pkg::*;
#(
    parameter int  WIDTH      = DEFAULT_WIDTH,
    parameter int  DEPTH      = DEFAULT_DEPTH,
    parameter int  ZERO_REG   = 1,
    parameter int  INIT_INDEX = 1,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [WIDTH-1:0]  reg1,
    output logic [WIDTH-1:0]  reg2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [WIDTH-1:0]  write_data,
    input  logic              wr_en,
    input  logic              sb_set_en,
    input  logic [ADDR_W-1:0] sb_set_reg,
    output logic              busy1,
    output logic              busy2,
    output logic              ready
);

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_init_ptr;
    logic [WIDTH-1:0]  r_regs [DEPTH];

    logic              w_ready;
    logic              w_init_last;
    logic [WIDTH-1:0]  w_init_val;
    logic              w_wr_ok;
    logic              w_sb_set_ok;
    logic              w_sb_busy1;
    logic              w_sb_busy2;
    logic              w_zero1;
    logic              w_zero2;
    logic              w_byp1;
    logic              w_byp2;

    assign w_ready     = (r_state == ST_RUN);
    assign w_init_last = (r_init_ptr == ADDR_W'(DEPTH - 1));
    assign w_init_val  = (INIT_INDEX != 0) ? WIDTH'(r_init_ptr) : '0;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_INIT: if (w_init_last) w_state_next = ST_RUN;
            ST_RUN:  w_state_next = ST_RUN;
            default: w_state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_INIT;
            r_init_ptr <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_INIT) begin
                r_init_ptr <= r_init_ptr + 1'b1;
            end
        end
    end

    assign w_wr_ok     = w_ready && wr_en &&
                         !((ZERO_REG != 0) && (write_reg == '0));
    assign w_sb_set_ok = w_ready && sb_set_en &&
                         !((ZERO_REG != 0) && (sb_set_reg == '0));

    // Array has no reset of its own; the init sequencer owns its contents after rst.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == ST_INIT) begin
                r_regs[r_init_ptr] <= w_init_val;
            end else if (w_wr_ok) begin
                r_regs[write_reg] <= write_data;
            end
        end
    end

    regfile_scoreboard #(
        .DEPTH (DEPTH)
    ) u_scoreboard (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_set_en   (w_sb_set_ok),
        .i_set_reg  (sb_set_reg),
        .i_clr_en   (w_ready && wr_en),
        .i_clr_reg  (write_reg),
        .i_rd_addr1 (read_reg1),
        .i_rd_addr2 (read_reg2),
        .o_busy1    (w_sb_busy1),
        .o_busy2    (w_sb_busy2)
    );

    assign w_zero1 = (ZERO_REG != 0) && (read_reg1 == '0);
    assign w_zero2 = (ZERO_REG != 0) && (read_reg2 == '0);

`ifdef REGFILE_BYPASS_EN
    assign w_byp1 = w_wr_ok && (write_reg == read_reg1);
    assign w_byp2 = w_wr_ok && (write_reg == read_reg2);
`else
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
`endif

    always_comb begin
        reg1  = '0;
        busy1 = 1'b0;
        if (w_ready && !w_zero1) begin
            if (w_byp1) begin
                reg1  = write_data;
                busy1 = w_sb_set_ok && (sb_set_reg == read_reg1);
            end else begin
                reg1  = r_regs[read_reg1];
                busy1 = w_sb_busy1;
            end
        end
    end

    always_comb begin
        reg2  = '0;
        busy2 = 1'b0;
        if (w_ready && !w_zero2) begin
            if (w_byp2) begin
                reg2  = write_data;
                busy2 = w_sb_set_ok && (sb_set_reg == read_reg2);
            end else begin
                reg2  = r_regs[read_reg2];
                busy2 = w_sb_busy2;
            end
        end
    end

    assign ready = w_ready;

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: table-driven and randomized checks of regfile_param against a behavioural model.
module tb_regfile_param;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int AW = 3;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [AW-1:0] read_reg1, read_reg2, write_reg, sb_set_reg;
    logic [W-1:0]  write_data, reg1, reg2;
    logic          wr_en, sb_set_en, busy1, busy2, ready;

    logic          x_rst;
    logic [4:0]    x_rd1, x_rd2, x_wa, x_sr;
    logic [31:0]   x_wd, x_reg1, x_reg2;
    logic          x_we, x_se, x_busy1, x_busy2, x_ready;

    regfile_param u_dut (
        .clk(clk), .rst(rst),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .reg1(reg1), .reg2(reg2),
        .write_reg(write_reg), .write_data(write_data), .wr_en(wr_en),
        .sb_set_en(sb_set_en), .sb_set_reg(sb_set_reg),
        .busy1(busy1), .busy2(busy2), .ready(ready)
    );

    regfile_param #(.WIDTH(32), .DEPTH(32)) u_dut32 (
        .clk(clk), .rst(x_rst),
        .read_reg1(x_rd1), .read_reg2(x_rd2),
        .reg1(x_reg1), .reg2(x_reg2),
        .write_reg(x_wa), .write_data(x_wd), .wr_en(x_we),
        .sb_set_en(x_se), .sb_set_reg(x_sr),
        .busy1(x_busy1), .busy2(x_busy2), .ready(x_ready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural reference: array contents, pending bits, init progress.
    logic [W-1:0] m_regs [D];
    logic [D-1:0] m_busy;
    bit           m_ready;
    int           m_ptr;

    task automatic model_rd(input logic [AW-1:0] r, output logic [W-1:0] d, output logic b);
        d = '0;
        b = 1'b0;
        if (m_ready && r != 0) begin
            if (BYP && wr_en && write_reg == r) begin
                d = write_data;
                b = sb_set_en && (sb_set_reg == r);
            end else begin
                d = m_regs[r];
                b = m_busy[r];
            end
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_ready = 1'b0;
            m_ptr   = 0;
            m_busy  = '0;
        end else if (!m_ready) begin
            m_regs[m_ptr] = W'(m_ptr);
            if (m_ptr == D - 1) m_ready = 1'b1;
            m_ptr++;
        end else begin
            if (wr_en && write_reg != 0) m_regs[write_reg] = write_data;
            if (wr_en) m_busy[write_reg] = 1'b0;
            if (sb_set_en && sb_set_reg != 0) m_busy[sb_set_reg] = 1'b1;
        end
    endtask

    typedef struct {
        logic          rs;
        logic [AW-1:0] r1, r2;
        logic          we;
        logic [AW-1:0] wa;
        logic [W-1:0]  wd;
        logic          se;
        logic [AW-1:0] sr;
        logic          chk;
        logic [W-1:0]  e1, e2;
        logic          eb1, eb2;
    } vec_t;

    function automatic vec_t mk(input logic [AW-1:0] r1, r2, input logic we, input logic [AW-1:0] wa,
                                input logic [W-1:0] wd, input logic se, input logic [AW-1:0] sr,
                                input logic [W-1:0] e1, e2, input logic eb1, eb2);
        vec_t v;
        v.rs = 1'b0; v.r1 = r1; v.r2 = r2; v.we = we; v.wa = wa; v.wd = wd;
        v.se = se; v.sr = sr; v.chk = 1'b1; v.e1 = e1; v.e2 = e2; v.eb1 = eb1; v.eb2 = eb2;
        return v;
    endfunction

    function automatic vec_t idle(input logic rs, input logic [AW-1:0] r1, r2);
        vec_t v;
        v = mk(r1, r2, 1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        v.rs  = rs;
        v.chk = 1'b0;
        return v;
    endfunction

    // Called at a negedge: drive, compare against model (and table if given), advance one edge.
    task automatic apply(input vec_t v, input string tag);
        logic [W-1:0] e1, e2;
        logic         eb1, eb2;
        rst = v.rs; read_reg1 = v.r1; read_reg2 = v.r2;
        wr_en = v.we; write_reg = v.wa; write_data = v.wd;
        sb_set_en = v.se; sb_set_reg = v.sr;
        #1;
        model_rd(read_reg1, e1, eb1);
        model_rd(read_reg2, e2, eb2);
        check({tag, "_ready"}, ready, m_ready);
        check({tag, "_reg1"},  reg1,  e1);
        check({tag, "_reg2"},  reg2,  e2);
        check({tag, "_busy1"}, busy1, eb1);
        check({tag, "_busy2"}, busy2, eb2);
        if (v.chk) begin
            check({tag, "_tbl_reg1"},  reg1,  v.e1);
            check({tag, "_tbl_reg2"},  reg2,  v.e2);
            check({tag, "_tbl_busy1"}, busy1, v.eb1);
            check({tag, "_tbl_busy2"}, busy2, v.eb2);
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [17];
        int   cnt;

        rst = 1'b1; x_rst = 1'b1;
        read_reg1 = '0; read_reg2 = '0; write_reg = '0; write_data = '0;
        wr_en = 1'b0; sb_set_en = 1'b0; sb_set_reg = '0;
        x_rd1 = '0; x_rd2 = '0; x_wa = '0; x_wd = '0; x_we = 1'b0; x_se = 1'b0; x_sr = '0;
        m_ready = 1'b0; m_ptr = 0; m_busy = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        apply(idle(1'b1, 3'd0, 3'd1), "reset");
        x_rst = 1'b0;

        for (int i = 0; i < D; i++) apply(idle(1'b0, 3'd2, 3'd5), "init");

        // reg | expected after init = index (reg 0 hardwired)
        tbl[0]  = mk(3'd0, 3'd1, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 16'h0001, 0, 0);
        tbl[1]  = mk(3'd2, 3'd3, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0002, 16'h0003, 0, 0);
        tbl[2]  = mk(3'd4, 3'd5, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0004, 16'h0005, 0, 0);
        tbl[3]  = mk(3'd6, 3'd7, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0006, 16'h0007, 0, 0);
        tbl[4]  = mk(3'd5, 3'd5, 1, 3'd5, 16'hBEEF, 0, 3'd0, BYP ? 16'hBEEF : 16'h0005,
                     BYP ? 16'hBEEF : 16'h0005, 0, 0);
        tbl[5]  = mk(3'd5, 3'd4, 0, 3'd0, 16'h0000, 0, 3'd0, 16'hBEEF, 16'h0004, 0, 0);
        tbl[6]  = mk(3'd0, 3'd0, 1, 3'd0, 16'hFFFF, 1, 3'd0, 16'h0000, 16'h0000, 0, 0);
        tbl[7]  = mk(3'd0, 3'd0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 16'h0000, 0, 0);
        tbl[8]  = mk(3'd3, 3'd3, 0, 3'd0, 16'h0000, 1, 3'd3, 16'h0003, 16'h0003, 0, 0);
        tbl[9]  = mk(3'd3, 3'd2, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0003, 16'h0002, 1, 0);
        tbl[10] = mk(3'd3, 3'd3, 1, 3'd3, 16'h0A0A, 0, 3'd0, BYP ? 16'h0A0A : 16'h0003,
                     BYP ? 16'h0A0A : 16'h0003, !BYP, !BYP);
        tbl[11] = mk(3'd3, 3'd3, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0A0A, 16'h0A0A, 0, 0);
        tbl[12] = mk(3'd3, 3'd3, 1, 3'd3, 16'h1111, 1, 3'd3, BYP ? 16'h1111 : 16'h0A0A,
                     BYP ? 16'h1111 : 16'h0A0A, BYP, BYP);
        tbl[13] = mk(3'd3, 3'd3, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h1111, 16'h1111, 1, 1);
        tbl[14] = mk(3'd4, 3'd2, 0, 3'd0, 16'h0000, 1, 3'd4, 16'h0004, 16'h0002, 0, 0);
        tbl[15] = mk(3'd2, 3'd4, 1, 3'd2, 16'h1234, 0, 3'd0, BYP ? 16'h1234 : 16'h0002,
                     16'h0004, 0, 1);
        tbl[16] = mk(3'd2, 3'd4, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h1234, 16'h0004, 0, 1);
        for (int i = 0; i < 17; i++) apply(tbl[i], "tbl");

        // Mid-run reset with reg 2 rewritten and reg 4 busy.
        apply(idle(1'b1, 3'd2, 3'd4), "midrst");
        cnt = 0;
        while (!ready && cnt < 100) begin
            apply(idle(1'b0, 3'd2, 3'd4), "reinit");
            cnt++;
        end
        check("reinit_len", cnt, D);
        apply(mk(3'd2, 3'd4, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0002, 16'h0004, 0, 0), "post_reinit");

        for (int i = 0; i < 400; i++) begin
            vec_t v;
            v = mk(AW'($urandom), AW'($urandom), 1'($urandom_range(0, 1)), AW'($urandom),
                   W'($urandom), 1'($urandom_range(0, 1)), AW'($urandom), '0, '0, 0, 0);
            v.rs  = ($urandom_range(0, 63) == 0);
            v.chk = 1'b0;
            if ($urandom_range(0, 3) == 0) v.wa = v.r1;
            if ($urandom_range(0, 3) == 0) v.sr = v.wa;
            apply(v, "rand");
        end

        // 32x32 instance: init length, index seeding, full-width write on both ports.
        x_rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        x_rst = 1'b0;
        #1;
        check("x_reset_ready", x_ready, 1'b0);
        cnt = 0;
        while (!x_ready && cnt < 200) begin
            @(posedge clk);
            @(negedge clk);
            cnt++;
        end
        check("x_init_len", cnt, 32);
        x_rd1 = 5'd31; x_rd2 = 5'd17;
        #1;
        check("x_init31", x_reg1, 32'd31);
        check("x_init17", x_reg2, 32'd17);
        @(negedge clk);
        x_rd2 = 5'd31; x_we = 1'b1; x_wa = 5'd31; x_wd = 32'hDEADBEEF;
        #1;
        check("x_wr_same_cycle1", x_reg1, BYP ? 32'hDEADBEEF : 32'd31);
        check("x_wr_same_cycle2", x_reg2, BYP ? 32'hDEADBEEF : 32'd31);
        @(posedge clk);
        @(negedge clk);
        x_we = 1'b0;
        #1;
        check("x_rd_port1", x_reg1, 32'hDEADBEEF);
        check("x_rd_port2", x_reg2, 32'hDEADBEEF);
        check("x_busy1", x_busy1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
